// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one word fetch per instruction, IFU->IDU valid/ready producer
module ifu_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h8000_0000,
   parameter int          RESP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        ifu_valid,
   output logic [63:0] ifu_data,
   output logic        ifu_fault,
   input  logic        idu_ready,
   input  logic        pc_update_valid,
   input  logic [31:0] pc_update,
   output logic        ifu_timeout,
   output logic [31:0] fetch_count
);

   localparam int CW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX  = CW'(RESP_TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(RESP_TIMEOUT - 1);

   typedef enum logic [1:0] {S_REQ, S_WAIT_RESP, S_HOLD, S_WAIT_PC} state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [CW-1:0] to_cnt;

   // Handshake outputs decode straight from the state register, so ifu_valid never sees idu_ready.
   assign mem_req_valid = (state == S_REQ);
   assign ifu_valid     = (state == S_HOLD);
   assign mem_req_addr  = {pc[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         ifu_data    <= 64'h0;
         ifu_fault   <= 1'b0;
         ifu_timeout <= 1'b0;
         fetch_count <= 32'h0;
         to_cnt      <= '0;
      end else begin
         case (state)
            S_REQ: begin
               // Any response arriving here is stale (e.g. from before a reset) and is dropped.
               if (mem_req_ready) begin
                  state  <= S_WAIT_RESP;
                  to_cnt <= '0;
               end
            end
            S_WAIT_RESP: begin
               if (mem_resp_valid) begin
                  ifu_data  <= {(mem_resp_err ? 32'h0 : mem_resp_data), pc};
                  ifu_fault <= mem_resp_err | (pc[1:0] != 2'b00);
                  state     <= S_HOLD;
               end else begin
                  if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
                  if (to_cnt == TO_LAST) ifu_timeout <= 1'b1;
               end
            end
            S_HOLD: begin
               if (idu_ready) begin
                  state       <= S_WAIT_PC;
                  fetch_count <= fetch_count + 32'd1;
               end
            end
            S_WAIT_PC: begin
               if (pc_update_valid) begin
                  pc    <= pc_update;
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed scoreboard bench for ifu_fetch
module tb_ifu_fetch;

   localparam int TO = 12;

   typedef struct packed {
      logic [63:0] data;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        ifu_valid;
   logic [63:0] ifu_data;
   logic        ifu_fault;
   logic        idu_ready;
   logic        pc_update_valid;
   logic [31:0] pc_update;
   logic        ifu_timeout;
   logic [31:0] fetch_count;

   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   exp_t sb[$];

   ifu_fetch #(.RESET_PC(32'h8000_0000), .RESP_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
      .ifu_valid(ifu_valid), .ifu_data(ifu_data), .ifu_fault(ifu_fault), .idu_ready(idu_ready),
      .pc_update_valid(pc_update_valid), .pc_update(pc_update),
      .ifu_timeout(ifu_timeout), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req_handshake(input logic [31:0] addr);
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_addr", 64'(mem_req_addr), 64'(addr));
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      chk("req_dropped", 64'(mem_req_valid), 64'd0);
   endtask

   task automatic respond(input logic [31:0] d, input logic e, input logic [63:0] xd, input logic xf);
      exp_t x;
      x.data  = xd;
      x.fault = xf;
      sb.push_back(x);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      mem_resp_err   = e;
      cyc();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      chk("bundle_valid", 64'(ifu_valid), 64'd1);
   endtask

   task automatic set_pc(input logic [31:0] p);
      pc_update_valid = 1'b1;
      pc_update       = p;
      cyc();
      pc_update_valid = 1'b0;
   endtask

   // Every accepted bundle is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && ifu_valid && idu_ready) begin
         exp_t e;
         hs_cnt++;
         chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("bundle_data", ifu_data, e.data);
            chk("bundle_fault", 64'(ifu_fault), 64'(e.fault));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      mem_resp_err = 1'b0; idu_ready = 1'b1; pc_update_valid = 1'b0; pc_update = 32'h0;
      repeat (2) cyc();
      chk("rst_req_valid", 64'(mem_req_valid), 64'd1);
      chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
      chk("rst_ifu_data", ifu_data, 64'h0);
      chk("rst_fault", 64'(ifu_fault), 64'd0);
      chk("rst_timeout", 64'(ifu_timeout), 64'd0);
      chk("rst_count", 64'(fetch_count), 64'd0);
      chk("rst_addr", 64'(mem_req_addr), 64'h8000_0000);

      // basic fetch with decoder ready
      rst = 1'b0;
      req_handshake(32'h8000_0000);
      cyc();
      chk("t1_no_early_valid", 64'(ifu_valid), 64'd0);
      respond(32'h0010_0093, 1'b0, 64'h0010_0093_8000_0000, 1'b0);
      cyc();
      chk("t1_valid_pulse", 64'(ifu_valid), 64'd0);
      chk("t1_count", 64'(fetch_count), 64'd1);
      chk("t1_hs", 64'(hs_cnt), 64'd1);

      // pc update then backpressure, with an ignored pulse during S_HOLD
      set_pc(32'h8000_0004);
      req_handshake(32'h8000_0004);
      idu_ready = 1'b0;
      cyc();
      respond(32'h0000_0013, 1'b0, 64'h0000_0013_8000_0004, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 64'(ifu_valid), 64'd1);
         chk("t2_hold_data", ifu_data, 64'h0000_0013_8000_0004);
         pc_update_valid = (i == 1);
         pc_update       = 32'h9000_0000;
         cyc();
      end
      pc_update_valid = 1'b0;
      chk("t2_no_hs_yet", 64'(hs_cnt), 64'd1);
      idu_ready = 1'b1;
      cyc();
      chk("t2_valid_drop", 64'(ifu_valid), 64'd0);
      chk("t2_count", 64'(fetch_count), 64'd2);
      cyc();
      chk("t2_no_dup", 64'(hs_cnt), 64'd2);
      chk("t2_wait_pc", 64'(mem_req_valid), 64'd0);

      // bus error, ignored pc pulse during S_WAIT_RESP, then misaligned pc
      set_pc(32'h8000_0008);
      req_handshake(32'h8000_0008);
      set_pc(32'h9000_0000);
      respond(32'hDEAD_BEEF, 1'b1, 64'h0000_0000_8000_0008, 1'b1);
      chk("t4_inst_zero", 64'(ifu_data[63:32]), 64'd0);
      cyc();
      set_pc(32'h8000_0006);
      req_handshake(32'h8000_0004);
      respond(32'h0000_0013, 1'b0, 64'h0000_0013_8000_0006, 1'b1);
      cyc();
      chk("t4_count", 64'(fetch_count), 64'd4);

      // response timeout, then late response
      set_pc(32'h8000_000C);
      req_handshake(32'h8000_000C);
      for (int i = 1; i < TO; i++) begin
         cyc();
         chk("t5_timeout_low", 64'(ifu_timeout), 64'd0);
      end
      cyc();
      chk("t5_timeout_rise", 64'(ifu_timeout), 64'd1);
      repeat (3) begin
         cyc();
         chk("t5_timeout_sticky", 64'(ifu_timeout), 64'd1);
         chk("t5_no_valid", 64'(ifu_valid), 64'd0);
      end
      respond(32'h0000_0073, 1'b0, 64'h0000_0073_8000_000C, 1'b0);
      cyc();
      chk("t5_timeout_kept", 64'(ifu_timeout), 64'd1);
      chk("t5_count", 64'(fetch_count), 64'd5);

      // reset mid-fetch and a stale response afterwards
      set_pc(32'h8000_0010);
      req_handshake(32'h8000_0010);
      cyc();
      rst = 1'b1;
      cyc();
      chk("t6_rst_req", 64'(mem_req_valid), 64'd1);
      chk("t6_rst_addr", 64'(mem_req_addr), 64'h8000_0000);
      chk("t6_rst_timeout", 64'(ifu_timeout), 64'd0);
      chk("t6_rst_count", 64'(fetch_count), 64'd0);
      rst = 1'b0;
      cyc();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_5678;
      cyc();
      mem_resp_valid = 1'b0;
      chk("t6_stale_dropped", 64'(ifu_valid), 64'd0);
      cyc();
      chk("t6_still_no_valid", 64'(ifu_valid), 64'd0);
      req_handshake(32'h8000_0000);
      cyc();
      respond(32'h0000_0093, 1'b0, 64'h0000_0093_8000_0000, 1'b0);
      cyc();
      chk("t6_count", 64'(fetch_count), 64'd1);
      chk("total_hs", 64'(hs_cnt), 64'd6);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
